eth_pkt_tx: RTL and testbench

ETH_PKT_TX -- requirements
Module: eth_pkt_tx

---
 rtl/eth_pkt_pkg.sv | 18 +
 rtl/eth_pkt_buf.sv | 38 +++
 rtl/eth_pkt_tx.sv | 192 +++++++++++++++++++
 tb/tb_eth_pkt_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkt_pkg.sv
// Shared definitions for the Ethernet packet transmitter: default widths,
// the largest payload the buffer can hold and the transmit FSM state type.
package eth_pkt_pkg;

  localparam int ETH_DATA_W        = 32;
  localparam int ETH_LEN_W         = 6;
  localparam int ETH_MAX_PLD_WORDS = 64;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SEND_DA  = 3'd2,
    S_SEND_SA  = 3'd3,
    S_SEND_PLD = 3'd4,
    S_GAP      = 3'd5
  } eth_tx_state_e;

endpackage

// File: rtl/eth_pkt_buf.sv
// Payload store for one packet: 2^LEN_W x DATA_W simple dual-port RAM.
// The write port is filled while loading; the read port has a registered
// output, so the caller presents the address of the word it will need on
// the following cycle (prefetch) and gets one word per cycle.
module eth_pkt_buf
  import eth_pkt_pkg::*;
#(
  parameter int DATA_W = ETH_DATA_W,
  parameter int LEN_W  = ETH_LEN_W
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [LEN_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [LEN_W-1:0]  rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int DEPTH = 1 << LEN_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write port: one payload word per accepted load beat.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port: registered read of the prefetched address.
  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/eth_pkt_tx.sv
// Store-and-forward Ethernet packet transmitter. Takes a header (DA, SA,
// length), buffers the whole payload, then drives DA(sop), SA, payload
// words (eop on last) toward a switch port that may stall, followed by an
// inter-frame gap of IFG_CYCLES idle cycles.
// Optional build macro ETH_PKT_TX_STATS_EN enables the pktCount counter;
// without it pktCount is tied to zero.
module eth_pkt_tx
  import eth_pkt_pkg::*;
#(
  parameter int DATA_W     = ETH_DATA_W,
  parameter int LEN_W      = ETH_LEN_W,
  parameter int IFG_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [DATA_W-1:0] reqDa,
  input  logic [DATA_W-1:0] reqSa,
  input  logic [LEN_W-1:0]  reqLen,
  input  logic              pldValid,
  input  logic [DATA_W-1:0] pldData,
  output logic              pldReady,
  output logic [DATA_W-1:0] outData,
  output logic              outSop,
  output logic              outEop,
  input  logic              portStall,
  output logic              busy,
  output logic [15:0]       pktCount
);

  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  eth_tx_state_e     state_q, state_d;
  logic [DATA_W-1:0] da_q, da_d;
  logic [DATA_W-1:0] sa_q, sa_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic              buf_we;
  logic [DATA_W-1:0] buf_rd_data;
  logic              in_send;
  logic              eop_taken;

  // Payload buffer; the read address is the next-cycle index so the word
  // needed when the output register advances is already at rd_data_o.
  eth_pkt_buf #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (buf_we),
    .wr_addr_i (idx_q),
    .wr_data_i (pldData),
    .rd_addr_i (idx_d),
    .rd_data_o (buf_rd_data)
  );

  assign in_send   = (state_q == S_SEND_DA) || (state_q == S_SEND_SA) ||
                     (state_q == S_SEND_PLD);
  assign eop_taken = (state_q == S_SEND_PLD) && out_eop_q && !portStall;

  // State register; reset returns to IDLE from any state, dropping the packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: sends advance only on unstalled cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (reqValid) state_d = S_LOAD;
      S_LOAD:     if (pldValid && (idx_q == len_q)) state_d = S_SEND_DA;
      S_SEND_DA:  if (!portStall) state_d = S_SEND_SA;
      S_SEND_SA:  if (!portStall) state_d = S_SEND_PLD;
      S_SEND_PLD: if (eop_taken) state_d = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:      if (gap_q == GAP_LAST) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; output word is selected by the state
  // being entered so that outData/outSop/outEop can be registered.
  always_comb begin
    reqReady   = (state_q == S_IDLE);
    pldReady   = (state_q == S_LOAD);
    busy       = (state_q != S_IDLE);
    buf_we     = (state_q == S_LOAD) && pldValid;
    da_d       = da_q;
    sa_d       = sa_q;
    len_d      = len_q;
    idx_d      = idx_q;
    gap_d      = '0;
    out_data_d = '0;
    out_sop_d  = 1'b0;
    out_eop_d  = 1'b0;

    if ((state_q == S_IDLE) && reqValid) begin
      da_d  = reqDa;
      sa_d  = reqSa;
      len_d = reqLen;
      idx_d = '0;
    end

    // Index walks the write side while loading and is cleared for readout.
    if (buf_we) begin
      idx_d = (idx_q == len_q) ? '0 : idx_q + 1'b1;
    end

    if (state_q == S_GAP) begin
      gap_d = gap_q + 1'b1;
    end

    if (in_send && portStall) begin
      out_data_d = out_data_q;
      out_sop_d  = out_sop_q;
      out_eop_d  = out_eop_q;
    end else begin
      case (state_d)
        S_SEND_DA: begin
          out_data_d = da_q;
          out_sop_d  = 1'b1;
        end
        S_SEND_SA: begin
          out_data_d = sa_q;
        end
        S_SEND_PLD: begin
          out_data_d = buf_rd_data;
          out_eop_d  = (idx_q == len_q);
          idx_d      = idx_q + 1'b1;
        end
        default: begin
          out_data_d = '0;
        end
      endcase
    end
  end

  // Control and output registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      gap_q      <= '0;
      out_data_q <= '0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      out_data_q <= out_data_d;
      out_sop_q  <= out_sop_d;
      out_eop_q  <= out_eop_d;
    end
  end

  // Header fields; only meaningful after a request is latched.
  always_ff @(posedge clk) begin
    da_q  <= da_d;
    sa_q  <= sa_d;
    len_q <= len_d;
  end

  assign outData = out_data_q;
  assign outSop  = out_sop_q;
  assign outEop  = out_eop_q;

`ifdef ETH_PKT_TX_STATS_EN
  logic [15:0] pkt_cnt_q;

  // Completed-packet counter, counts eop words taken by the port; wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_q <= '0;
    end else if (eop_taken) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pktCount = pkt_cnt_q;
`else
  assign pktCount = 16'd0;
`endif

endmodule

// File: tb/tb_eth_pkt_tx.sv
// Self-checking bench for eth_pkt_tx. Each packet is described by its
// expected word list {DA, SA, payload...}; the bench walks that list as the
// port consumes words, and checks the gap, counter and idle behaviour.
module tb_eth_pkt_tx;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 6;
  localparam int IFG    = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              reqValid;
  logic              reqReady;
  logic [DATA_W-1:0] reqDa;
  logic [DATA_W-1:0] reqSa;
  logic [LEN_W-1:0]  reqLen;
  logic              pldValid;
  logic [DATA_W-1:0] pldData;
  logic              pldReady;
  logic [DATA_W-1:0] outData;
  logic              outSop;
  logic              outEop;
  logic              portStall;
  logic              busy;
  logic [15:0]       pktCount;

  int checks = 0;
  int errors = 0;
  int exp_pkts = 0;
  logic [DATA_W-1:0] pld [$];

  always #5 clk = ~clk;

  eth_pkt_tx #(
    .DATA_W     (DATA_W),
    .LEN_W      (LEN_W),
    .IFG_CYCLES (IFG)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqDa     (reqDa),
    .reqSa     (reqSa),
    .reqLen    (reqLen),
    .pldValid  (pldValid),
    .pldData   (pldData),
    .pldReady  (pldReady),
    .outData   (outData),
    .outSop    (outSop),
    .outEop    (outEop),
    .portStall (portStall),
    .busy      (busy),
    .pktCount  (pktCount)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt();
`ifdef ETH_PKT_TX_STATS_EN
    return exp_pkts[15:0];
`else
    return 16'h0;
`endif
  endfunction

  // pmode: 0 payload every cycle, 1 every other cycle, 2 random gaps.
  // smode: 0 no stall, 1 stall 3 cycles on SA, 2 random stalls + junk pldValid.
  // abort_k: word index at which reset is asserted (-1 = never).
  task automatic send_pkt(input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] sa,
                          input int pmode, input int smode, input int abort_k);
    logic [DATA_W-1:0] exp_q [$];
    int n, i, k, cyc, guard, idle_run, stall_run, sa_cycles, st_done;
    logic v, s;
    n = pld.size();
    exp_q = {da, sa};
    foreach (pld[j]) exp_q.push_back(pld[j]);

    guard = 0;
    while (!reqReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("hdr_reqReady", reqReady, 1);
    chk("hdr_idle_busy", busy, 0);
    reqValid = 1'b1;
    reqDa    = da;
    reqSa    = sa;
    reqLen   = LEN_W'(n - 1);
    @(negedge clk);
    reqValid = 1'b0;
    reqDa    = $urandom;
    reqSa    = $urandom;
    reqLen   = LEN_W'($urandom);

    // Load: nothing may appear on the port until the payload is complete.
    i = 0; cyc = 0; idle_run = 0;
    while (i < n) begin
      chk("load_pldReady", pldReady, 1);
      chk("load_reqReady", reqReady, 0);
      chk("load_busy", busy, 1);
      chk("load_outSop", outSop, 0);
      chk("load_outData", outData, 0);
      if (pmode == 0)      v = 1'b1;
      else if (pmode == 1) v = (cyc % 2) == 1;
      else                 v = ($urandom_range(0, 2) != 0) || (idle_run >= 3);
      pldValid = v;
      pldData  = v ? pld[i] : $urandom;
      if (v) begin i++; idle_run = 0; end
      else idle_run++;
      @(negedge clk);
      cyc++;
    end
    pldValid = 1'b0;

    // Send: first word must appear right after the last payload beat.
    k = 0; stall_run = 0; sa_cycles = 0; st_done = 0;
    while (k < n + 2) begin
      chk("send_outData", outData, exp_q[k]);
      chk("send_outSop", outSop, k == 0);
      chk("send_outEop", outEop, k == n + 1);
      chk("send_busy", busy, 1);
      chk("send_pldReady", pldReady, 0);
      chk("send_pktCount", pktCount, exp_cnt());
      if (k == 1) sa_cycles++;
      if (k == abort_k) begin
        reset     = 1'b1;
        portStall = 1'b0;
        pldValid  = 1'b0;
        @(negedge clk);
        chk("abort_outData", outData, 0);
        chk("abort_outSop", outSop, 0);
        chk("abort_outEop", outEop, 0);
        chk("abort_busy", busy, 0);
        chk("abort_reqReady", reqReady, 1);
        chk("abort_pktCount", pktCount, 0);
        reset    = 1'b0;
        exp_pkts = 0;
        return;
      end
      if (smode == 1)      s = (k == 1) && (st_done < 3);
      else if (smode == 2) s = ($urandom_range(0, 3) == 0) && (stall_run < 3);
      else                 s = 1'b0;
      if (s) begin st_done++; stall_run++; end
      else stall_run = 0;
      portStall = s;
      if (smode == 2) begin
        pldValid = 1'($urandom_range(0, 1));
        pldData  = $urandom;
      end
      if (!s) k++;
      @(negedge clk);
    end
    portStall = 1'b0;
    pldValid  = 1'b0;
    exp_pkts++;
    if (smode == 1) chk("sa_hold_cycles", sa_cycles, 4);

    // Inter-frame gap then back to idle.
    for (int g = 0; g < IFG; g++) begin
      chk("gap_outData", outData, 0);
      chk("gap_outSop", outSop, 0);
      chk("gap_outEop", outEop, 0);
      chk("gap_busy", busy, 1);
      chk("gap_reqReady", reqReady, 0);
      chk("gap_pktCount", pktCount, exp_cnt());
      @(negedge clk);
    end
    chk("post_busy", busy, 0);
    chk("post_reqReady", reqReady, 1);
    chk("post_outData", outData, 0);
  endtask

  initial begin
    reset     = 1'b1;
    reqValid  = 1'b0;
    reqDa     = '0;
    reqSa     = '0;
    reqLen    = '0;
    pldValid  = 1'b0;
    pldData   = '0;
    portStall = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outData", outData, 0);
    chk("rst_outSop", outSop, 0);
    chk("rst_outEop", outEop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reqReady", reqReady, 1);
    chk("rst_pldReady", pldReady, 0);
    chk("rst_pktCount", pktCount, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Basic 3-word packet, no stall.
    pld = {32'd1, 32'd2, 32'd3};
    send_pkt(32'hAAAA0001, 32'hBBBB0002, 0, 0, -1);

    // Same packet with a 3-cycle stall on SA.
    send_pkt(32'hAAAA0001, 32'hBBBB0002, 0, 1, -1);

    // Single-word payload.
    pld = {32'h55};
    send_pkt($urandom, $urandom, 0, 0, -1);

    // Maximum payload, loaded on alternate cycles.
    pld.delete();
    for (int j = 0; j < 64; j++) pld.push_back($urandom);
    send_pkt($urandom, $urandom, 1, 0, -1);

    // Reset on the 3rd payload word of a 10-word packet, then a clean one.
    pld.delete();
    for (int j = 0; j < 10; j++) pld.push_back($urandom);
    send_pkt($urandom, $urandom, 0, 0, 4);
    send_pkt($urandom, $urandom, 0, 0, -1);
    pld = {32'hDEAD0001, 32'hDEAD0002};
    send_pkt($urandom, $urandom, 2, 0, -1);
    send_pkt($urandom, $urandom, 0, 2, -1);
`ifdef ETH_PKT_TX_STATS_EN
    chk("pktCount_three", pktCount, 3);
`else
    chk("pktCount_three", pktCount, 0);
`endif

    // Randomised packets: lengths, gaps, stalls and stray pldValid.
    for (int p = 0; p < 12; p++) begin
      int n;
      n = $urandom_range(1, 64);
      pld.delete();
      for (int j = 0; j < n; j++) pld.push_back($urandom);
      send_pkt($urandom, $urandom, 2, 2, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
